// File: rtl/cpu_types_pkg.sv
// Shared types for the coherent memory bus: word and RAM handshake types,
// plus the bus controller state encoding.
package cpu_types_pkg;

  localparam int CPUS   = 2;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    FWD,
    DRAM,
    IRAM
  } busstate_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter with two priority classes: any dcache request
// outranks every icache request; ties inside a class go to the core that was not served last.
module rr_arbiter
  import cpu_types_pkg::*;
(
  input  logic [CPUS-1:0] dreq_i,
  input  logic [CPUS-1:0] ireq_i,
  input  logic            last_grant_i,
  output logic            grant_o,
  output logic            is_d_o,
  output logic            valid_o
);

  logic [CPUS-1:0] cls;

  always_comb begin
    is_d_o  = |dreq_i;
    cls     = is_d_o ? dreq_i : ireq_i;
    valid_o = |cls;
    grant_o = (&cls) ? ~last_grant_i : cls[1];
  end

endmodule

// File: rtl/coherent_bus_ctrl.sv
// Memory-side bus controller for two cores: arbitrates I/D requests onto one RAM port,
// runs the dcache snoop handshake and forwards dirty snooped words cache-to-cache.
module coherent_bus_ctrl
  import cpu_types_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic     [CPUS-1:0] iREN,
  input  word_t    [CPUS-1:0] iaddr,
  output word_t    [CPUS-1:0] iload,
  output logic     [CPUS-1:0] iwait,
  input  logic     [CPUS-1:0] dREN,
  input  logic     [CPUS-1:0] dWEN,
  input  word_t    [CPUS-1:0] daddr,
  input  word_t    [CPUS-1:0] dstore,
  output word_t    [CPUS-1:0] dload,
  output logic     [CPUS-1:0] dwait,
  input  logic     [CPUS-1:0] cctrans,
  input  logic     [CPUS-1:0] ccwrite,
  output logic     [CPUS-1:0] ccwait,
  output logic     [CPUS-1:0] ccinv,
  output word_t    [CPUS-1:0] ccsnoopaddr,
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate
);

  busstate_t state_q, state_d;
  logic      grant_q, grant_d;
  logic      last_grant_q, last_grant_d;
  word_t     addr_q, addr_d;
  word_t     data_q, data_d;
  logic      write_q, write_d;
  logic      inv_q, inv_d;

  logic arb_grant, arb_is_d, arb_valid;
  logic other;
  logic done;

  rr_arbiter u_arb (
    .dreq_i       (dREN | dWEN),
    .ireq_i       (iREN),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .is_d_o       (arb_is_d),
    .valid_o      (arb_valid)
  );

  assign other = ~grant_q;
  assign done  = (ramstate == ACCESS) && (state_q inside {FWD, DRAM, IRAM});

  // The request is captured at arbitration so a requester that drops out
  // mid-transaction cannot disturb the RAM access already under way.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    write_d      = write_q;
    inv_d        = inv_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          if (arb_is_d) begin
            addr_d  = daddr[arb_grant];
            data_d  = dstore[arb_grant];
            write_d = dWEN[arb_grant];
            inv_d   = ccwrite[arb_grant];
            state_d = cctrans[arb_grant] ? SNOOP : DRAM;
          end else begin
            addr_d  = iaddr[arb_grant];
            write_d = 1'b0;
            inv_d   = 1'b0;
            state_d = IRAM;
          end
        end
      end
      SNOOP: begin
        if (ccwrite[other]) begin
          data_d  = dstore[other];
          state_d = FWD;
        end else begin
          state_d = DRAM;
        end
      end
      default: begin
        if (done) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: the datapath registers carry no reset; IDLE reloads them before any state reads them.
  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    data_q  <= data_d;
    write_q <= write_d;
    inv_q   <= inv_d;
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state_q)
      SNOOP: begin
        ccwait[other]      = 1'b1;
        ccinv[other]       = inv_q;
        ccsnoopaddr[other] = addr_q;
      end
      FWD: begin
        ccwait[other]      = 1'b1;
        ccsnoopaddr[other] = addr_q;
        ramWEN             = 1'b1;
        ramaddr            = addr_q;
        ramstore           = data_q;
        dload[grant_q]     = data_q;
        dwait[grant_q]     = ~done;
      end
      DRAM: begin
        ramREN         = ~write_q;
        ramWEN         = write_q;
        ramaddr        = addr_q;
        ramstore       = data_q;
        dload[grant_q] = ramload;
        dwait[grant_q] = ~done;
      end
      IRAM: begin
        ramREN         = 1'b1;
        ramaddr        = addr_q;
        iload[grant_q] = ramload;
        iwait[grant_q] = ~done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// Self-checking bench for coherent_bus_ctrl: directed scenarios plus randomized
// batches checked against a transaction-level model of arbitration, snooping and memory.
module tb_coherent_bus_ctrl;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] iREN, dREN, dWEN, cctrans, ccwrite;
  logic [1:0] iwait, dwait, ccwait, ccinv;
  word_t [1:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
  logic       ramREN, ramWEN;
  word_t      ramaddr, ramstore, ramload;
  ramstate_t  ramstate = FREE;

  int n_checks = 0;
  int n_errors = 0;

  int    ram_lat  = 0;
  int    err_left = 0;
  int    lat_cnt  = 0;
  word_t ram_mem[word_t];
  word_t ref_mem[word_t];
  bit    lg = 1'b0;

  int    mon_ccw[2];
  bit    mon_inv[2];
  word_t mon_saddr[2];

  coherent_bus_ctrl dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  function automatic word_t init_word(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic word_t rd(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // RAM: err_left ERROR cycles, then ram_lat BUSY cycles, then ACCESS; writes commit on ACCESS.
  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      if (err_left > 0) begin
        ramstate = ERROR;
        err_left--;
      end else if (lat_cnt < ram_lat) begin
        ramstate = BUSY;
        lat_cnt++;
      end else begin
        ramstate = ACCESS;
        lat_cnt  = 0;
        if (ramWEN) ram_mem[ramaddr] = ramstore;
      end
    end else begin
      ramstate = FREE;
      lat_cnt  = 0;
    end
    ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
  end

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  // Waits for any wait line to drop, behaving like the cache: the served request is withdrawn at once.
  task automatic wait_any(input int budget, output bit ok, output bit got_d, output int got_c,
                          output word_t got_data, output int cyc);
    ok = 1'b0; got_d = 1'b0; got_c = 0; got_data = '0; cyc = 0;
    mon_ccw = '{0, 0}; mon_inv = '{1'b0, 1'b0}; mon_saddr = '{32'h0, 32'h0};
    while (!ok && cyc < budget) begin
      @(negedge CLK); #1;
      cyc++;
      for (int c = 0; c < 2; c++) begin
        if (ccwait[c]) begin mon_ccw[c]++; mon_saddr[c] = ccsnoopaddr[c]; end
        if (ccinv[c]) mon_inv[c] = 1'b1;
      end
      for (int c = 0; c < 2; c++)
        if (!ok && !dwait[c]) begin
          ok = 1'b1; got_d = 1'b1; got_c = c; got_data = dload[c];
          if (cctrans[c]) ccwrite[c] = 1'b0;
          dREN[c] = 1'b0; dWEN[c] = 1'b0; cctrans[c] = 1'b0;
        end
      for (int c = 0; c < 2; c++)
        if (!ok && !iwait[c]) begin
          ok = 1'b1; got_d = 1'b0; got_c = c; got_data = iload[c];
          iREN[c] = 1'b0;
        end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    n_checks++; if (iwait !== 2'b11) begin n_errors++; $display("FAIL reset_iwait: got %b expected 11", iwait); end
    n_checks++; if (dwait !== 2'b11) begin n_errors++; $display("FAIL reset_dwait: got %b expected 11", dwait); end
    n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes: got %b expected 00", {ramREN, ramWEN}); end
    n_checks++; if (ccwait !== 2'b00 || ccinv !== 2'b00) begin n_errors++; $display("FAIL reset_cc: got ccwait=%b ccinv=%b expected 00/00", ccwait, ccinv); end
    n_checks++; if (ccsnoopaddr !== '0) begin n_errors++; $display("FAIL reset_snoopaddr: got %h expected 0", ccsnoopaddr); end
    n_checks++; if (iload !== '0 || dload !== '0) begin n_errors++; $display("FAIL reset_loads: got iload=%h dload=%h expected 0", iload, dload); end
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    n_checks++; if (dut.state_q !== IDLE) begin n_errors++; $display("FAIL reset_idle: got state %0d expected IDLE", dut.state_q); end
    n_checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin n_errors++; $display("FAIL idle_waits: got %b/%b expected 11/11", iwait, dwait); end
    lg = 1'b0;
  endtask

  task automatic test_iread();
    bit ok, gd; int gc, cyc; word_t gdata;
    @(posedge CLK); #1;
    ram_lat = 1;
    ram_mem[32'h100] = 32'hDEAD_BEEF;
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    wait_any(40, ok, gd, gc, gdata, cyc);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL iread_timeout: got no completion expected iwait[0]=0"); end
    n_checks++; if (gd !== 1'b0 || gc !== 0) begin n_errors++; $display("FAIL iread_who: got d=%0d core=%0d expected i core 0", gd, gc); end
    n_checks++; if (gdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL iread_data: got %h expected deadbeef", gdata); end
    n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL iread_latency: got %0d expected 3", cyc); end
    @(negedge CLK); #1;
    n_checks++; if (iwait[0] !== 1'b1) begin n_errors++; $display("FAIL iread_one_cycle: got iwait[0]=%b expected 1", iwait[0]); end
    lg = 1'b0;
  endtask

  task automatic test_d_over_i();
    bit ok, gd; int gc, cyc; word_t gdata;
    @(posedge CLK); #1;
    ram_lat = 0;
    ram_mem[32'h200] = 32'h0BAD_F00D;
    dREN[0] = 1'b1; daddr[0] = 32'h200;
    iREN[1] = 1'b1; iaddr[1] = 32'h300;
    wait_any(40, ok, gd, gc, gdata, cyc);
    n_checks++; if (!ok || gd !== 1'b1 || gc !== 0) begin n_errors++; $display("FAIL dfirst_who: got ok=%0d d=%0d core=%0d expected d core 0", ok, gd, gc); end
    n_checks++; if (gdata !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL dfirst_data: got %h expected 0badf00d", gdata); end
    n_checks++; if (iwait[1] !== 1'b1) begin n_errors++; $display("FAIL dfirst_iwait_held: got %b expected 1", iwait[1]); end
    wait_any(40, ok, gd, gc, gdata, cyc);
    n_checks++; if (!ok || gd !== 1'b0 || gc !== 1) begin n_errors++; $display("FAIL ilater_who: got ok=%0d d=%0d core=%0d expected i core 1", ok, gd, gc); end
    n_checks++; if (gdata !== init_word(32'h300)) begin n_errors++; $display("FAIL ilater_data: got %h expected %h", gdata, init_word(32'h300)); end
    n_checks++; if (cyc !== 2) begin n_errors++; $display("FAIL ilater_latency: got %0d expected 2", cyc); end
    lg = 1'b1;
  endtask

  task automatic test_fwd();
    bit ok, gd; int gc, cyc; word_t gdata;
    @(posedge CLK); #1;
    ram_lat = 1;
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b0; daddr[0] = 32'h40;
    ccwrite[1] = 1'b1; dstore[1] = 32'h1234_5678;
    wait_any(40, ok, gd, gc, gdata, cyc);
    n_checks++; if (!ok || gd !== 1'b1 || gc !== 0) begin n_errors++; $display("FAIL fwd_who: got ok=%0d d=%0d core=%0d expected d core 0", ok, gd, gc); end
    n_checks++; if (gdata !== 32'h1234_5678) begin n_errors++; $display("FAIL fwd_data: got %h expected 12345678", gdata); end
    n_checks++; if (mon_ccw[1] !== 3 || mon_ccw[0] !== 0) begin n_errors++; $display("FAIL fwd_ccwait: got %0d/%0d cycles expected 3/0", mon_ccw[1], mon_ccw[0]); end
    n_checks++; if (mon_inv[1] !== 1'b0) begin n_errors++; $display("FAIL fwd_ccinv: got %b expected 0", mon_inv[1]); end
    n_checks++; if (mon_saddr[1] !== 32'h40) begin n_errors++; $display("FAIL fwd_snoopaddr: got %h expected 40", mon_saddr[1]); end
    n_checks++; if (!ram_mem.exists(32'h40) || ram_mem[32'h40] !== 32'h1234_5678) begin n_errors++; $display("FAIL fwd_ram_write: got %h expected 12345678", ram_mem[32'h40]); end
    n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL fwd_latency: got %0d expected 4", cyc); end
    ccwrite[1] = 1'b0;
    lg = 1'b0;
  endtask

  task automatic test_inv_write();
    bit ok, gd; int gc, cyc; word_t gdata;
    @(posedge CLK); #1;
    ram_lat = 0;
    dWEN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h80; dstore[1] = 32'hCAFE_F00D;
    ccwrite[0] = 1'b0; dstore[0] = 32'hFFFF_0000;
    wait_any(40, ok, gd, gc, gdata, cyc);
    n_checks++; if (!ok || gd !== 1'b1 || gc !== 1) begin n_errors++; $display("FAIL inv_who: got ok=%0d d=%0d core=%0d expected d core 1", ok, gd, gc); end
    n_checks++; if (mon_inv[0] !== 1'b1) begin n_errors++; $display("FAIL inv_ccinv: got %b expected 1", mon_inv[0]); end
    n_checks++; if (mon_ccw[0] !== 1) begin n_errors++; $display("FAIL inv_ccwait: got %0d cycles expected 1", mon_ccw[0]); end
    n_checks++; if (mon_saddr[0] !== 32'h80) begin n_errors++; $display("FAIL inv_snoopaddr: got %h expected 80", mon_saddr[0]); end
    n_checks++; if (!ram_mem.exists(32'h80) || ram_mem[32'h80] !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL inv_ram_write: got %h expected cafef00d", ram_mem[32'h80]); end
    n_checks++; if (cyc !== 3) begin n_errors++; $display("FAIL inv_latency: got %0d expected 3", cyc); end
    lg = 1'b1;
  endtask

  task automatic test_round_robin();
    bit ok, gd; int gc, cyc, exp_c, exp_cyc; word_t gdata;
    bit [1:0] pend;
    @(posedge CLK); #1;
    ram_lat  = 0;
    err_left = 3;
    for (int r = 0; r < 4; r++) begin
      pend = 2'b11;
      for (int c = 0; c < 2; c++) begin
        dREN[c] = 1'b1; daddr[c] = 32'h500 + 32'(r * 2 + c);
      end
      for (int k = 0; k < 2; k++) begin
        exp_c   = (pend == 2'b11) ? (lg ? 0 : 1) : (pend[1] ? 1 : 0);
        exp_cyc = (r == 0 && k == 0) ? 5 : 2;
        wait_any(40, ok, gd, gc, gdata, cyc);
        n_checks++; if (!ok || gd !== 1'b1 || gc !== exp_c) begin n_errors++; $display("FAIL rr_grant r%0d k%0d: got ok=%0d core=%0d expected core %0d", r, k, ok, gc, exp_c); end
        n_checks++; if (gdata !== init_word(32'h500 + 32'(r * 2 + exp_c))) begin n_errors++; $display("FAIL rr_data r%0d k%0d: got %h expected %h", r, k, gdata, init_word(32'h500 + 32'(r * 2 + exp_c))); end
        n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL rr_latency r%0d k%0d: got %0d expected %0d", r, k, cyc, exp_cyc); end
        pend[exp_c] = 1'b0;
        lg = (exp_c == 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    ram_lat = 8;
    iREN[1] = 1'b1; iaddr[1] = 32'h700;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (ramREN !== 1'b1) begin n_errors++; $display("FAIL midrst_active: got ramREN=%b expected 1", ramREN); end
    RST = 1'b1; iREN = '0;
    @(posedge CLK); #1;
    n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_errors++; $display("FAIL midrst_strobes: got %b expected 00", {ramREN, ramWEN}); end
    n_checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin n_errors++; $display("FAIL midrst_waits: got %b/%b expected 11/11", iwait, dwait); end
    RST = 1'b0;
    ram_lat = 0;
    lg = 1'b0;
  endtask

  task automatic test_random();
    bit ok, gd, coh, dirty, intent, pred_d;
    int gc, cyc, req, oth, pred_c;
    word_t gdata, snoop_data;
    bit [1:0] pi, pd, wen;
    for (int b = 0; b < 40; b++) begin
      @(posedge CLK); #1;
      clear_inputs();
      ram_lat = $urandom_range(0, 2);
      pi  = 2'($urandom_range(0, 3));
      pd  = 2'($urandom_range(0, 3));
      wen = 2'($urandom_range(0, 3)) & pd;
      coh = 1'b0; dirty = 1'b0; intent = 1'b0; req = 0; oth = 1; snoop_data = '0;
      if ((pd == 2'b01 || pd == 2'b10) && $urandom_range(0, 1) == 1) begin
        coh = 1'b1; req = pd[1] ? 1 : 0; oth = 1 - req;
        dirty = 1'($urandom_range(0, 1)); intent = 1'($urandom_range(0, 1));
        snoop_data = $urandom();
      end
      for (int c = 0; c < 2; c++) begin
        if (pi[c]) begin iREN[c] = 1'b1; iaddr[c] = 32'h1000 + 32'($urandom_range(0, 7)); end
        if (pd[c]) begin
          daddr[c] = 32'h1000 + 32'($urandom_range(0, 7));
          dstore[c] = $urandom();
          dWEN[c] = wen[c]; dREN[c] = ~wen[c];
        end
      end
      if (coh) begin
        cctrans[req] = 1'b1; ccwrite[req] = intent;
        ccwrite[oth] = dirty; dstore[oth] = snoop_data;
      end
      while ((pi | pd) != 2'b00) begin
        pred_d = (pd != 2'b00);
        if (pred_d) pred_c = (pd == 2'b11) ? (lg ? 0 : 1) : (pd[1] ? 1 : 0);
        else        pred_c = (pi == 2'b11) ? (lg ? 0 : 1) : (pi[1] ? 1 : 0);
        wait_any(60, ok, gd, gc, gdata, cyc);
        n_checks++;
        if (!ok) begin
          n_errors++; $display("FAIL rnd_timeout b%0d: got no completion expected core %0d", b, pred_c);
          clear_inputs();
          break;
        end
        n_checks++; if (gd !== pred_d || gc !== pred_c) begin n_errors++; $display("FAIL rnd_order b%0d: got d=%0d core=%0d expected d=%0d core=%0d", b, gd, gc, pred_d, pred_c); end
        if (!pred_d) begin
          n_checks++; if (gdata !== rd(iaddr[pred_c])) begin n_errors++; $display("FAIL rnd_iload b%0d: got %h expected %h", b, gdata, rd(iaddr[pred_c])); end
        end else if (coh && pred_c == req) begin
          n_checks++; if (mon_ccw[oth] !== (dirty ? ram_lat + 2 : 1)) begin n_errors++; $display("FAIL rnd_ccwait b%0d: got %0d expected %0d", b, mon_ccw[oth], dirty ? ram_lat + 2 : 1); end
          n_checks++; if (mon_inv[oth] !== intent) begin n_errors++; $display("FAIL rnd_ccinv b%0d: got %b expected %b", b, mon_inv[oth], intent); end
          n_checks++; if (mon_saddr[oth] !== daddr[req]) begin n_errors++; $display("FAIL rnd_snoopaddr b%0d: got %h expected %h", b, mon_saddr[oth], daddr[req]); end
          if (dirty) begin
            n_checks++; if (gdata !== snoop_data) begin n_errors++; $display("FAIL rnd_fwd_data b%0d: got %h expected %h", b, gdata, snoop_data); end
            ref_mem[daddr[req]] = snoop_data;
          end else if (wen[req]) begin
            ref_mem[daddr[req]] = dstore[req];
          end else begin
            n_checks++; if (gdata !== rd(daddr[req])) begin n_errors++; $display("FAIL rnd_coh_read b%0d: got %h expected %h", b, gdata, rd(daddr[req])); end
          end
        end else if (wen[pred_c]) begin
          ref_mem[daddr[pred_c]] = dstore[pred_c];
        end else begin
          n_checks++; if (gdata !== rd(daddr[pred_c])) begin n_errors++; $display("FAIL rnd_dload b%0d: got %h expected %h", b, gdata, rd(daddr[pred_c])); end
        end
        if (pred_d) pd[pred_c] = 1'b0;
        else        pi[pred_c] = 1'b0;
        lg = (pred_c == 1);
      end
      ccwrite = '0;
    end
    foreach (ref_mem[a]) begin
      n_checks++;
      if (!ram_mem.exists(a) || ram_mem[a] !== ref_mem[a]) begin
        n_errors++; $display("FAIL rnd_ram_image @%h: got %h expected %h", a, ram_mem.exists(a) ? ram_mem[a] : 32'h0, ref_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_iread();
    test_d_over_i();
    test_fwd();
    test_inv_write();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected completion within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
